// File: rtl/usb_fifo_rx_if.sv
// Bundles the 245-sync FIFO chip read bus and the AXI-Stream style output port.
// master = usb_fifo_rx (drives the chip strobes and the stream), slave = chip/sink side.
interface usb_fifo_rx_if #(
  parameter int FIFO_BUS_WIDTH = 4
);
  logic                          usb_rxf_n;
  logic                          usb_oe_n;
  logic                          usb_rd_n;
  logic [FIFO_BUS_WIDTH*8-1:0]   usb_data_i;
  logic [FIFO_BUS_WIDTH-1:0]     usb_be_i;
  logic [FIFO_BUS_WIDTH*8-1:0]   m_tdata;
  logic [FIFO_BUS_WIDTH-1:0]     m_tkeep;
  logic                          m_tvalid;
  logic                          m_tready;
  logic                          m_tlast;

  modport master (
    input  usb_rxf_n, usb_data_i, usb_be_i, m_tready,
    output usb_oe_n, usb_rd_n, m_tdata, m_tkeep, m_tvalid, m_tlast
  );

  modport slave (
    output usb_rxf_n, usb_data_i, usb_be_i, m_tready,
    input  usb_oe_n, usb_rd_n, m_tdata, m_tkeep, m_tvalid, m_tlast
  );
endinterface

// File: rtl/usb_fifo_rx.sv
// 245-sync FIFO chip read engine feeding a skid buffer with a backpressured stream port.
// Optional macro USB_FIFO_RX_TLAST_EN stores a per-word tlast flag (short word or burst limit).
//
// state   | meaning
// IDLE    | bus released, waiting for rxf_n low and two free buffer slots
// TURN    | oe_n low, one-cycle bus turnaround
// READ    | oe_n and rd_n low, one word captured per cycle while data is available
// END     | rd_n high, one cycle before releasing oe_n
module usb_fifo_rx #(
  parameter int FIFO_BUS_WIDTH  = 4,
  parameter int SKID_DEPTH      = 4,
  parameter int MAX_BURST_WORDS = 1024
) (
  input  logic             usb_clk,
  input  logic             rst_glbl,
  usb_fifo_rx_if.master    bus,
  output logic             rx_busy
);
  localparam int DW  = FIFO_BUS_WIDTH * 8;
  localparam int BW  = FIFO_BUS_WIDTH;
  localparam int PW  = $clog2(SKID_DEPTH);
  localparam int CW  = $clog2(SKID_DEPTH + 1);
  localparam int BCW = $clog2(MAX_BURST_WORDS + 1);
`ifdef USB_FIFO_RX_TLAST_EN
  localparam int EW  = DW + BW + 1;
`else
  localparam int EW  = DW + BW;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_TURN, ST_READ, ST_END} state_e;

  state_e          state_q;
  logic            oe_n_q;
  logic            rd_n_q;
  logic [BCW-1:0]  burst_cnt_q;
  logic [BCW-1:0]  burst_cnt_d;
  logic [EW-1:0]   mem_q [SKID_DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [EW-1:0]   entry_d;
  logic [EW-1:0]   head;
  logic            push;
  logic            pop;

  // rd_n_q is low only in READ, so a capture never happens outside a burst.
  assign push = !rd_n_q && !bus.usb_rxf_n;
  assign pop  = (count_q != '0) && bus.m_tready;

  always_comb begin
    count_d     = count_q + CW'(push) - CW'(pop);
    burst_cnt_d = burst_cnt_q + BCW'(push);
  end

`ifdef USB_FIFO_RX_TLAST_EN
  always_comb begin
    entry_d = {(bus.usb_be_i != {BW{1'b1}}) || (burst_cnt_d == BCW'(MAX_BURST_WORDS)),
               bus.usb_data_i, bus.usb_be_i};
  end
  assign bus.m_tlast = head[EW-1];
`else
  always_comb begin
    entry_d = {bus.usb_data_i, bus.usb_be_i};
  end
  assign bus.m_tlast = 1'b0;
`endif

  assign head         = mem_q[rd_ptr_q];
  assign bus.m_tvalid = (count_q != '0);
  assign bus.m_tdata  = head[BW +: DW];
  assign bus.m_tkeep  = head[BW-1:0];
  assign bus.usb_oe_n = oe_n_q;
  assign bus.usb_rd_n = rd_n_q;
  assign rx_busy      = (state_q != ST_IDLE);

  always_ff @(posedge usb_clk) begin
    if (rst_glbl) begin
      state_q     <= ST_IDLE;
      oe_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      burst_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= entry_d;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      burst_cnt_q <= (state_q == ST_IDLE) ? '0 : burst_cnt_d;

      case (state_q)
        ST_IDLE: begin
          if (!bus.usb_rxf_n && (SKID_DEPTH - int'(count_q)) >= 2) begin
            state_q <= ST_TURN;
            oe_n_q  <= 1'b0;
          end
        end
        ST_TURN: begin
          state_q <= ST_READ;
          rd_n_q  <= 1'b0;
        end
        ST_READ: begin
          // Leaving one slot free covers nothing here since rd_n is registered,
          // but keeps the buffer strictly below full between bursts.
          if (bus.usb_rxf_n || int'(count_d) >= SKID_DEPTH - 1 ||
              int'(burst_cnt_d) >= MAX_BURST_WORDS) begin
            state_q <= ST_END;
            rd_n_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          oe_n_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule
